// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, block geometry,
// and the algorithm constants used by the compression datapath.
package sha256_pkg;

    localparam int SHA_ROUNDS   = 64;
    localparam int SHA_WORDS    = 16;
    // Cycles per block: 16 loads, 1 write-drain, 64 rounds, 1 hash fold.
    localparam int BLOCK_CYCLES = SHA_WORDS + 1 + SHA_ROUNDS + 1;

    // Counter widths are exact: 16 words and 64 rounds.
    localparam int K_W   = 4;
    localparam int RND_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LWAIT  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Initial hash value H0..H7.
    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants K[0..63].
    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // K-constant lookup for the datapath, indexed by round_idx.
    function automatic logic [31:0] k_const(input logic [RND_W-1:0] idx);
        return K_TABLE[idx];
    endfunction

endpackage

// File: rtl/sha256_msg_addr_gen.sv
// Message read path: latches the base address, tracks block and word
// counters, forms the registered read address, and produces the schedule
// write strobe/index one cycle behind each read.
module sha256_msg_addr_gen
    import sha256_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NBLK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              blk_inc_i,
    input  logic              rd_en_d_i,
    output logic              msg_rd_en_o,
    output logic [ADDR_W-1:0] msg_addr_o,
    output logic              w_wr_en_o,
    output logic [K_W-1:0]    w_wr_idx_o,
    output logic [K_W-1:0]    k_o,
    output logic [NBLK_W-1:0] blk_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [NBLK_W-1:0] blk_q, blk_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q;
    logic [K_W-1:0]    wr_idx_q;

    // Next counters and the address of the read issued next cycle; the
    // block offset is {blk,0000} truncated so addresses wrap modulo 2^ADDR_W.
    always_comb begin
        base_d = base_q;
        blk_d  = blk_q;
        k_d    = k_q;
        if (capture_i) begin
            base_d = base_addr_i;
            blk_d  = '0;
            k_d    = '0;
        end else begin
            if (blk_inc_i) blk_d = blk_q + 1'b1;
            // k wraps 15 -> 0 on the last load, ready for the next block.
            if (rd_en_q)   k_d   = k_q + 1'b1;
        end
        addr_d = addr_q;
        if (rd_en_d_i) begin
            addr_d = base_d + ADDR_W'({blk_d, {K_W{1'b0}}}) + ADDR_W'(k_d);
        end
    end

    // Base address is pure data and only meaningful after a capture.
    always_ff @(posedge clock) begin
        base_q <= base_d;
    end

    // Counters, read strobe/address, and the write strobe trailing the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            blk_q    <= '0;
            k_q      <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            blk_q    <= blk_d;
            k_q      <= k_d;
            rd_en_q  <= rd_en_d_i;
            addr_q   <= addr_d;
            wr_en_q  <= rd_en_q;
            wr_idx_q <= k_q;
        end
    end

    assign msg_rd_en_o = rd_en_q;
    assign msg_addr_o  = addr_q;
    assign w_wr_en_o   = wr_en_q;
    assign w_wr_idx_o  = wr_idx_q;
    assign k_o         = k_q;
    assign blk_o       = blk_q;

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: for each message block, loads 16 words into the
// schedule, runs 64 compression rounds, folds into the hash state, and
// pulses done after the last block. Every output is a register.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NBLK_W = 8,
    parameter int ROUNDS = SHA_ROUNDS,
    parameter int WORDS  = SHA_WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NBLK_W-1:0] num_blocks,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              msg_rd_en,
    output logic [ADDR_W-1:0] msg_addr,
    output logic              w_wr_en,
    output logic [3:0]        w_wr_idx,
    output logic              hash_init,
    output logic              round_en,
    output logic [5:0]        round_idx,
    output logic              hash_update,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [NBLK_W-1:0] num_q, num_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              hash_init_q, hash_init_d;
    logic              round_en_q, round_en_d;
    logic              hash_update_q, hash_update_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              capture;
    logic              blk_inc;
    logic              rd_en_d;
    logic              blk_last;
    logic [K_W-1:0]    k_cur;
    logic [NBLK_W-1:0] blk_cur;

    sha256_msg_addr_gen #(
        .ADDR_W (ADDR_W),
        .NBLK_W (NBLK_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .capture_i   (capture),
        .base_addr_i (base_addr),
        .blk_inc_i   (blk_inc),
        .rd_en_d_i   (rd_en_d),
        .msg_rd_en_o (msg_rd_en),
        .msg_addr_o  (msg_addr),
        .w_wr_en_o   (w_wr_en),
        .w_wr_idx_o  (w_wr_idx),
        .k_o         (k_cur),
        .blk_o       (blk_cur)
    );

    // Compare one bit wider so blk+1 cannot overflow against num_blocks.
    assign blk_last = ((NBLK_W+1)'(blk_cur) + (NBLK_W+1)'(1)) >= (NBLK_W+1)'(num_q);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE, so pulses while
    // busy (including the DONE cycle) are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (num_blocks != '0) ? ST_LOAD : ST_DONE;
            end
            ST_LOAD: begin
                if (k_cur == K_W'(WORDS - 1)) state_d = ST_LWAIT;
            end
            ST_LWAIT:  state_d = ST_ROUND;
            ST_ROUND: begin
                if (round_q == RND_W'(ROUNDS - 1)) state_d = ST_UPDATE;
            end
            ST_UPDATE: state_d = blk_last ? ST_DONE : ST_LOAD;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: strobes are decoded from the next state so that they
    // are registered and line up with the state they belong to.
    always_comb begin
        capture       = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        num_d         = capture ? num_blocks : num_q;
        blk_inc       = (state_q == ST_UPDATE);
        rd_en_d       = (state_d == ST_LOAD);
        hash_init_d   = capture;
        round_en_d    = (state_d == ST_ROUND);
        hash_update_d = (state_d == ST_UPDATE);
        done_d        = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
        // Round index restarts on entry to ROUND and otherwise holds.
        round_d       = round_q;
        if (state_q == ST_LWAIT) begin
            round_d = '0;
        end else if ((state_q == ST_ROUND) && (state_d == ST_ROUND)) begin
            round_d = round_q + 1'b1;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            num_q         <= '0;
            round_q       <= '0;
            hash_init_q   <= 1'b0;
            round_en_q    <= 1'b0;
            hash_update_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            num_q         <= num_d;
            round_q       <= round_d;
            hash_init_q   <= hash_init_d;
            round_en_q    <= round_en_d;
            hash_update_q <= hash_update_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign hash_init   = hash_init_q;
    assign round_en    = round_en_q;
    assign round_idx   = round_q;
    assign hash_update = hash_update_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
Top-level sequencer for the SHA-256 core. On a start pulse it walks N 512-bit message blocks through three phases per block:
- load 16 message words from message memory into the schedule registers;
- step the compression datapath through 64 rounds;
- fold the working variables into the hash state.
It then raises a one-cycle done. It replaces ad-hoc enable flops around the message path with a single FSM, and owns every datapath enable.

Parameters:
ADDR_W, 8, message memory word-address width
NBLK_W, 8, width of block-count input
ROUNDS, 64, compression rounds per block
WORDS, 16, 32-bit message words per block

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle go pulse; sampled only in IDLE
num_blocks  in  NBLK_W  blocks to hash; captured with start
base_addr  in  ADDR_W  word address of block 0 word 0; captured with start
msg_rd_en  out  1  message memory read strobe
msg_addr  out  ADDR_W  message memory read address
w_wr_en  out  1  schedule register write; data is memory output from the read one cycle earlier
w_wr_idx  out  4  schedule register index 0..15
hash_init  out  1  load H0..H7 initial constants into the hash state
round_en  out  1  advance compression datapath one round
round_idx  out  6  current round 0..63; drives K-constant ROM and W select
hash_update  out  1  H[i] <= H[i] + working var[i]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All outputs are registered.
- Reset: state=IDLE; all outputs 0; internal counters 0. Reset mid-operation aborts immediately. No done is issued for an aborted run.
- States: IDLE, LOAD, LWAIT, ROUND, UPDATE, DONE.
- IDLE:
  - start=1 and num_blocks!=0: capture base_addr and num_blocks; clear blk and word counters; go to LOAD.
  - start=1 and num_blocks==0: go to DONE (done only, no datapath strobes).
  - start while busy: ignored, not queued.
- LOAD (16 cycles, k=0..15):
  - msg_rd_en=1; msg_addr = base + blk*16 + k, modulo 2^ADDR_W (wrap permitted).
  - hash_init=1 only in the k=0 cycle of block 0.
  - After k=15, go to LWAIT.
- w_wr_en / w_wr_idx: the 1-cycle-delayed copies of msg_rd_en and k. Writes occur in LOAD cycles k=1..15 and in LWAIT.
- LWAIT (1 cycle): last write lands; go to ROUND with round_idx=0.
- ROUND (64 cycles): round_en=1; round_idx increments 0..63. After 63, go to UPDATE.
- UPDATE (1 cycle): hash_update=1; blk increments.
  - If blk+1 < num_blocks: go to LOAD, no hash_init.
  - Else: go to DONE.
- DONE (1 cycle): done=1, busy=1; then go to IDLE. start in this cycle is ignored.
- Timing: each block takes 82 cycles (16+1+64+1).
  - Start sampled at edge 0 gives the first LOAD in cycle 1 and done in cycle 1+82N.
  - num_blocks==0 gives done in cycle 1.
- Mutual exclusion: msg_rd_en, round_en, hash_update and done are never high in the same cycle. round_idx holds its last value outside ROUND.
- Width rules:
  - blk*16 is computed as {blk,4'b0} truncated to ADDR_W.
  - Counters are sized exactly: k is 4 bits, round is 6 bits, blk is NBLK_W bits.

Decomposition:
- Shared package sha256_pkg:
  - state enum;
  - ROUNDS, WORDS and the per-block cycle constant 82;
  - H0..H7 initial values and the K-constant table, shared with the datapath.
- One natural sub-module, sha256_msg_addr_gen: base register, blk/k counters, address adder, and the 1-cycle-delayed w_wr_en / w_wr_idx.

Test Plan:
- Reset, then start, base=0x10, N=1 → hash_init in cycle 1; reads 0x10..0x1F in cycles 1–16; w_wr_idx 0..15 in cycles 2–17; round_en cycles 18–81 with round_idx 0..63; hash_update in cycle 82; done in cycle 83; busy high in cycles 1–83.
- N=3, base=0x00 → block 2 reads 0x20..0x2F; exactly 3 hash_update pulses; hash_init only once; done in cycle 247.
- N=0 → done in cycle 1 only; no rd/round/hash strobes; busy high for 1 cycle.
- base=0xF8, N=1, ADDR_W=8 → addresses 0xF8..0xFF, then wrap to 0x00..0x07.
- start pulses during ROUND and in the DONE cycle → ignored; exactly one done per accepted start.
- reset asserted at round_idx=30 → next cycle IDLE with all outputs 0; no done; a fresh start then completes normally.
